aes_out_serializer: RTL

- Downstream stage of the AES_128 core: captures the 128-bit result when the core pulses done.
- Buffers up to DEPTH completed blocks, tagged with the mode (encrypt/decrypt) that produced them.
- Streams each block out as 16 bytes over a valid/ready byte interface, so the core never has to wait on the consumer.
- Decouples the core's one-cycle done pulse from a byte-wide sink (UART/bus bridge).

---
 rtl/aes_out_if.sv | 30 +++
 rtl/aes_out_serializer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/aes_out_if.sv
// Byte-stream interface between the AES output serializer and a byte-wide sink.
//   byte_o        current output byte
//   byte_valid_o  byte_o holds a valid byte
//   byte_ready_i  sink accepts the byte when valid && ready
//   byte_last_o   marks the 16th byte of a block
//   mode_o        mode tag (encrypt/decrypt) of the block being streamed
// master: the serializer, slave: the sink.
interface aes_out_if;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_ready_i;
  logic       byte_last_o;
  logic       mode_o;

  modport master (
    output byte_o,
    output byte_valid_o,
    output byte_last_o,
    output mode_o,
    input  byte_ready_i
  );

  modport slave (
    input  byte_o,
    input  byte_valid_o,
    input  byte_last_o,
    input  mode_o,
    output byte_ready_i
  );
endinterface

// File: rtl/aes_out_serializer.sv
// AES output serializer.
// Captures the 128-bit AES core result on its one-cycle done pulse, buffers up
// to DEPTH blocks tagged with their mode, and streams each block as 16 bytes
// over a valid/ready byte interface. All outputs are registered.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   done_i         one-cycle capture strobe, text_i/inv_i valid with it
//   text_i         128-bit block from the core
//   inv_i          mode tag stored with the block
//   bus            aes_out_if.master byte stream (byte/valid/ready/last/mode)
//   count_o        blocks held, including the one streaming
//   ovf_o          one-cycle pulse after a done_i was dropped (buffer full)
//   drop_cnt_o     saturating dropped-block counter (only with
//                  AES_OUT_DROP_CNT_EN defined)
//
// Parameters:
//   DEPTH      block slots, power of 2, >= 2
//   MSB_FIRST  1: byte 0 is text[127:120]; 0: byte 0 is text[7:0]
//
// Optional feature macro: AES_OUT_DROP_CNT_EN
//
// state  | meaning
// IDLE   | no block streaming, byte_valid_o low
// STREAM | bytes of entry[rd_ptr] presented, idx selects the byte
module aes_out_serializer #(
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     done_i,
  input  logic [127:0]             text_i,
  input  logic                     inv_i,
  aes_out_if.master                bus,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o
`ifdef AES_OUT_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE   = (PW+1)'(1);

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t        state;
  logic [128:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [3:0]    idx;

  logic          accept;
  logic          pop;
  logic          full;
  logic          drop;
  logic          push;
  logic [128:0]  cur_entry;
  logic [128:0]  nxt_entry;

  function automatic logic [7:0] sel_byte(input logic [127:0] t, input logic [3:0] i);
    if (MSB_FIRST != 0) return t[{4'd15 - i, 3'b000} +: 8];
    else                return t[{i, 3'b000} +: 8];
  endfunction

  always_comb begin
    accept    = bus.byte_valid_o && bus.byte_ready_i;
    pop       = accept && bus.byte_last_o;
    full      = (count_o == FULL);
    drop      = done_i && full && !pop;
    push      = done_i && !drop;
    rd_next   = rd_ptr + 1'b1;
    cur_entry = mem[rd_ptr];
    // With a single block held, the follow-on block is being written this
    // very cycle, so forward it straight from the inputs to avoid a bubble.
    nxt_entry = (push && count_o == ONE) ? {inv_i, text_i} : mem[rd_next];
  end

  // Storage is not reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {inv_i, text_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      idx              <= '0;
      count_o          <= '0;
      ovf_o            <= 1'b0;
      bus.byte_o       <= '0;
      bus.byte_valid_o <= 1'b0;
      bus.byte_last_o  <= 1'b0;
      bus.mode_o       <= 1'b0;
    end else begin
      ovf_o <= drop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_next;

      case ({push, pop})
        2'b10:   count_o <= count_o + ONE;
        2'b01:   count_o <= count_o - ONE;
        default: count_o <= count_o;
      endcase

      case (state)
        ST_IDLE: begin
          if (count_o != '0) begin
            state            <= ST_STREAM;
            idx              <= 4'd0;
            bus.byte_valid_o <= 1'b1;
            bus.byte_o       <= sel_byte(cur_entry[127:0], 4'd0);
            bus.byte_last_o  <= 1'b0;
            bus.mode_o       <= cur_entry[128];
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (idx == 4'd15) begin
              if (count_o > ONE || push) begin
                idx             <= 4'd0;
                bus.byte_o      <= sel_byte(nxt_entry[127:0], 4'd0);
                bus.byte_last_o <= 1'b0;
                bus.mode_o      <= nxt_entry[128];
              end else begin
                state            <= ST_IDLE;
                idx              <= 4'd0;
                bus.byte_valid_o <= 1'b0;
                bus.byte_last_o  <= 1'b0;
              end
            end else begin
              idx             <= idx + 4'd1;
              bus.byte_o      <= sel_byte(cur_entry[127:0], idx + 4'd1);
              bus.byte_last_o <= (idx == 4'd14);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AES_OUT_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_cnt_o <= 8'h00;
    else if (drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'h01;
  end
`endif

endmodule
